// File: rtl/ddr2_pio_pkg.sv
// Shared constants for the DDR2 board-control bidirectional PIO.
package ddr2_pio_pkg;

  localparam int unsigned ADDR_W = 3;

  localparam logic [ADDR_W-1:0] ADDR_DATA    = 3'd0;
  localparam logic [ADDR_W-1:0] ADDR_DIR     = 3'd1;
  localparam logic [ADDR_W-1:0] ADDR_IRQMASK = 3'd2;
  localparam logic [ADDR_W-1:0] ADDR_EDGECAP = 3'd3;
  localparam logic [ADDR_W-1:0] ADDR_OUTSET  = 3'd4;
  localparam logic [ADDR_W-1:0] ADDR_OUTCLR  = 3'd5;

  localparam int unsigned EDGE_RISE = 0;
  localparam int unsigned EDGE_FALL = 1;
  localparam int unsigned EDGE_ANY  = 2;

endpackage

// File: rtl/ddr2_bidir_pio_if.sv
// Avalon-MM slave bus bundle for ddr2_bidir_pio.
interface ddr2_bidir_pio_if
  import ddr2_pio_pkg::*;
#(
  parameter int unsigned WIDTH = 8
);

  logic [ADDR_W-1:0] address;
  logic              chipselect;
  logic              write_n;
  logic [WIDTH-1:0]  writedata;
  logic [WIDTH-1:0]  readdata;
  logic              irq;

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata, irq
  );

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata, irq
  );

endinterface

// File: rtl/ddr2_pio_sync.sv
// WIDTH-wide, SYNC_STAGES-deep flop synchroniser with async active-low reset.
module ddr2_pio_sync #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [SYNC_STAGES-1:0][WIDTH-1:0] chain;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      chain <= '0;
    end else begin
      chain <= {chain[SYNC_STAGES-2:0], d};
    end
  end

  assign q = chain[SYNC_STAGES-1];

endmodule

// File: rtl/ddr2_bidir_pio.sv
// Bidirectional PIO slave: direction, set/clear outputs, synced inputs, edge capture, irq.
// Define PIO_OPEN_DRAIN_EN for open-drain pins (never driven high); default is push-pull.
module ddr2_bidir_pio
  import ddr2_pio_pkg::*;
#(
  parameter int unsigned      WIDTH       = 8,
  parameter int unsigned      SYNC_STAGES = 2,
  parameter int unsigned      EDGE_TYPE   = 0,
  parameter logic [WIDTH-1:0] RESET_DIR   = '0,
  parameter logic [WIDTH-1:0] RESET_OUT   = '0
) (
  input  logic                   clk,
  input  logic                   reset_n,
  ddr2_bidir_pio_if.slave        bus,
  inout  wire        [WIDTH-1:0] bidir_port
);

  logic [WIDTH-1:0] data_out, data_out_nxt;
  logic [WIDTH-1:0] data_dir, data_dir_nxt;
  logic [WIDTH-1:0] irq_mask, irq_mask_nxt;
  logic [WIDTH-1:0] edge_cap, edge_cap_nxt;
  logic [WIDTH-1:0] sync_in, sync_prev;
  logic [WIDTH-1:0] rise, fall, edge_det;
  logic [WIDTH-1:0] rd_mux;
  logic             wr_en;

  ddr2_pio_sync #(
    .WIDTH       (WIDTH),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (bidir_port),
    .q       (sync_in)
  );

  always_comb begin
    rise = sync_in & ~sync_prev;
    fall = ~sync_in & sync_prev;
    if (EDGE_TYPE == EDGE_FALL) begin
      edge_det = fall;
    end else if (EDGE_TYPE == EDGE_ANY) begin
      edge_det = rise | fall;
    end else begin
      edge_det = rise;
    end
  end

  // Register writes; a fresh edge overrides a same-cycle write-1-clear.
  always_comb begin
    wr_en        = bus.chipselect & ~bus.write_n;
    data_out_nxt = data_out;
    data_dir_nxt = data_dir;
    irq_mask_nxt = irq_mask;
    edge_cap_nxt = edge_cap;
    if (wr_en) begin
      case (bus.address)
        ADDR_DATA:    data_out_nxt = bus.writedata;
        ADDR_DIR:     data_dir_nxt = bus.writedata;
        ADDR_IRQMASK: irq_mask_nxt = bus.writedata;
        ADDR_EDGECAP: edge_cap_nxt = edge_cap & ~bus.writedata;
        ADDR_OUTSET:  data_out_nxt = data_out | bus.writedata;
        ADDR_OUTCLR:  data_out_nxt = data_out & ~bus.writedata;
        default:      ;
      endcase
    end
    edge_cap_nxt = edge_cap_nxt | edge_det;
  end

  always_comb begin
    rd_mux = '0;
    case (bus.address)
      ADDR_DATA:    rd_mux = sync_in;
      ADDR_DIR:     rd_mux = data_dir;
      ADDR_IRQMASK: rd_mux = irq_mask;
      ADDR_EDGECAP: rd_mux = edge_cap;
      default:      rd_mux = '0;
    endcase
  end

  // irq is built from next-state values so it rises with edge_cap and drops with its clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_out     <= RESET_OUT;
      data_dir     <= RESET_DIR;
      irq_mask     <= '0;
      edge_cap     <= '0;
      sync_prev    <= '0;
      bus.readdata <= '0;
      bus.irq      <= 1'b0;
    end else begin
      data_out     <= data_out_nxt;
      data_dir     <= data_dir_nxt;
      irq_mask     <= irq_mask_nxt;
      edge_cap     <= edge_cap_nxt;
      sync_prev    <= sync_in;
      bus.readdata <= rd_mux;
      bus.irq      <= |(edge_cap_nxt & irq_mask_nxt);
    end
  end

  for (genvar i = 0; i < int'(WIDTH); i++) begin : g_pin
`ifdef PIO_OPEN_DRAIN_EN
    assign bidir_port[i] = (data_dir[i] & ~data_out[i]) ? 1'b0 : 1'bz;
`else
    assign bidir_port[i] = data_dir[i] ? data_out[i] : 1'bz;
`endif
  end

endmodule

// File: tb/tb_ddr2_bidir_pio.sv
// Directed self-checking bench for ddr2_bidir_pio (WIDTH=8, SYNC_STAGES=2, rising edges).
module tb_ddr2_bidir_pio;
  import ddr2_pio_pkg::*;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [7:0] ext_en;
  logic [7:0] ext_val;
  logic [7:0] rdv;
  wire  [7:0] pins;
  int         total = 0;
  int         bad   = 0;

  ddr2_bidir_pio_if #(.WIDTH(8)) bus_if ();

  ddr2_bidir_pio #(
    .WIDTH       (8),
    .SYNC_STAGES (2),
    .EDGE_TYPE   (0),
    .RESET_DIR   (8'h00),
    .RESET_OUT   (8'h00)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .bus        (bus_if.slave),
    .bidir_port (pins)
  );

  for (genvar i = 0; i < 8; i++) begin : g_board
    pullup pu (pins[i]);
    assign pins[i] = ext_en[i] ? ext_val[i] : 1'bz;
  end

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%02h expected 0x%02h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Bus tasks are entered and left just after a falling edge.
  task automatic wr(input logic [2:0] a, input logic [7:0] d);
    bus_if.address    = a;
    bus_if.writedata  = d;
    bus_if.chipselect = 1'b1;
    bus_if.write_n    = 1'b0;
    @(negedge clk);
    bus_if.chipselect = 1'b0;
    bus_if.write_n    = 1'b1;
  endtask

  task automatic rd(input logic [2:0] a, output logic [7:0] d);
    bus_if.address = a;
    @(negedge clk);
    d = bus_if.readdata;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation ran too long");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n           = 1'b0;
    ext_en            = '0;
    ext_val           = '0;
    bus_if.address    = '0;
    bus_if.chipselect = 1'b0;
    bus_if.write_n    = 1'b1;
    bus_if.writedata  = '0;
    #1;
    chk("rst_readdata", bus_if.readdata, 8'h00);
    chk("rst_irq", 8'(bus_if.irq), 8'h00);
    chk("rst_pins_z", pins, 8'hFF);
    tick(2);
    reset_n = 1'b1;

    // Reset readback; the zeroed synchroniser filling with pulled-up levels looks like rising edges.
    rd(ADDR_EDGECAP, rdv); chk("rst_edgecap", rdv, 8'h00);
    rd(ADDR_DATA, rdv);    chk("data_sync_early", rdv, 8'h00);
    rd(ADDR_DATA, rdv);    chk("data_after_3clk", rdv, 8'hFF);
    rd(ADDR_DIR, rdv);     chk("rst_dir", rdv, 8'h00);
    rd(ADDR_IRQMASK, rdv); chk("rst_irqmask", rdv, 8'h00);
    rd(ADDR_OUTSET, rdv);  chk("rd_outset", rdv, 8'h00);
    rd(ADDR_OUTCLR, rdv);  chk("rd_outclr", rdv, 8'h00);
    rd(ADDR_EDGECAP, rdv); chk("startup_edges", rdv, 8'hFF);
    chk("irq_masked", 8'(bus_if.irq), 8'h00);
    wr(ADDR_EDGECAP, 8'hFF);
    rd(ADDR_EDGECAP, rdv); chk("edgecap_clr_all", rdv, 8'h00);

    // Direction + set/clear: data_out = (A5|40)&~01 = E4.
    wr(ADDR_DIR, 8'h0F);
    wr(ADDR_DATA, 8'hA5);
    wr(ADDR_OUTSET, 8'h40);
    wr(ADDR_OUTCLR, 8'h01);
    chk("pins_mixed", pins, 8'hF4);
    rd(ADDR_DIR, rdv);     chk("dir_rb", rdv, 8'h0F);
    tick(2);
    rd(ADDR_DATA, rdv);    chk("data_rb_F4", rdv, 8'hF4);
    rd(ADDR_EDGECAP, rdv); chk("own_toggle_edges", rdv, 8'h05);
    wr(ADDR_EDGECAP, 8'h05);
    rd(ADDR_EDGECAP, rdv); chk("edgecap_clr_05", rdv, 8'h00);

    // External rise on pin 5 with irq enabled: edge_cap and irq exactly 3 clocks later.
    ext_en[5]  = 1'b1;
    ext_val[5] = 1'b0;
    tick(4);
    wr(ADDR_EDGECAP, 8'hFF);
    wr(ADDR_IRQMASK, 8'h20);
    chk("irq_before_edge", 8'(bus_if.irq), 8'h00);
    ext_val[5] = 1'b1;
    tick(2);
    chk("irq_at_2clk", 8'(bus_if.irq), 8'h00);
    tick(1);
    chk("irq_at_3clk", 8'(bus_if.irq), 8'h01);
    rd(ADDR_EDGECAP, rdv); chk("edgecap_pin5", rdv, 8'h20);
    wr(ADDR_EDGECAP, 8'h20);
    chk("irq_after_clr", 8'(bus_if.irq), 8'h00);
    rd(ADDR_EDGECAP, rdv); chk("edgecap_pin5_clr", rdv, 8'h00);
    ext_en[5] = 1'b0;

    // Rising edge on bit 2 lands in the same cycle as its write-1-clear: set wins.
    wr(ADDR_OUTCLR, 8'h04);
    tick(4);
    wr(ADDR_OUTSET, 8'h04);
    tick(2);
    wr(ADDR_EDGECAP, 8'h04);
    rd(ADDR_EDGECAP, rdv); chk("set_wins", rdv, 8'h04);
    wr(ADDR_EDGECAP, 8'h04);
    rd(ADDR_EDGECAP, rdv); chk("late_clear", rdv, 8'h00);

    // Asynchronous reset while all pins are driven.
    wr(ADDR_DIR, 8'hFF);
    chk("pins_all_out", pins, 8'hE4);
    wr(ADDR_IRQMASK, 8'hFF);
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_pins_z", pins, 8'hFF);
    chk("async_readdata", bus_if.readdata, 8'h00);
    chk("async_irq", 8'(bus_if.irq), 8'h00);
    @(negedge clk);
    reset_n = 1'b1;
    rd(ADDR_EDGECAP, rdv); chk("rst2_edgecap", rdv, 8'h00);
    rd(ADDR_DIR, rdv);     chk("rst2_dir", rdv, 8'h00);
    rd(ADDR_IRQMASK, rdv); chk("rst2_irqmask", rdv, 8'h00);
    rd(ADDR_DATA, rdv);    chk("rst2_data", rdv, 8'hFF);

    // Upper nibble driven low, lower nibble high (driven or released to the pull-up).
    wr(ADDR_DIR, 8'hFF);
    wr(ADDR_DATA, 8'h0F);
    chk("pins_0F", pins, 8'h0F);
    tick(2);
    rd(ADDR_DATA, rdv);    chk("data_rb_0F", rdv, 8'h0F);
`ifdef PIO_OPEN_DRAIN_EN
    // A released high pin can be pulled low by another device on the wire.
    ext_en[0]  = 1'b1;
    ext_val[0] = 1'b0;
    tick(3);
    chk("od_wired_and_pin", pins, 8'h0E);
    rd(ADDR_DATA, rdv);    chk("od_wired_and_data", rdv, 8'h0E);
    ext_en[0] = 1'b0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
